hart_miss_sched: RTL and testbench

Cache-miss scheduler for the 4-hart pipeline. Records I-cache and D-cache misses per hart, removes the missing hart from the active set, and arbitrates the single shared refill port round-robin across harts. On refill completion it returns the hart to the active set. It sits between the IF/MEM cache controllers and the hart state table, and produces the `acti_hstate` consumed by the issue selector.

---
 rtl/hart_miss_sched_pkg.sv | 24 ++
 rtl/hart_miss_sched_picker.sv | 36 +++
 rtl/hart_miss_sched.sv | 164 ++++++++++++++++
 tb/tb_hart_miss_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hart_miss_sched_pkg.sv
// -----------------------------------------------------------------------------
// hart_miss_sched_pkg
// Shared constants for the cache-miss scheduler: hart-state bus widths and the
// refill-port FSM encodings. No ports.
// -----------------------------------------------------------------------------
package hart_miss_sched_pkg;

    localparam int HART_STATE_W = 4;   // one bit per hart
    localparam int HART_ID_W    = 2;   // hart id width

    typedef logic [HART_STATE_W-1:0] hart_mask_t;
    typedef logic [HART_ID_W-1:0]    hart_id_t;

    // Refill-port FSM encodings
    localparam logic [1:0] MS_IDLE = 2'd0;
    localparam logic [1:0] MS_REQ  = 2'd1;
    localparam logic [1:0] MS_BUSY = 2'd2;

    // One-hot mask for a hart id
    function automatic hart_mask_t hid_onehot(input hart_id_t hid);
        return hart_mask_t'(1) << hid;
    endfunction

endpackage

// File: rtl/hart_miss_sched_picker.sv
// -----------------------------------------------------------------------------
// rr_hart_picker
// Combinational round-robin picker over the four harts.
//   req_i   : per-hart request mask (any pending refill)
//   rr_i    : hart id with highest priority this cycle
//   valid_o : at least one request present
//   hid_o   : winning hart id (first requester at or after rr_i, wrapping)
// -----------------------------------------------------------------------------
module rr_hart_picker
    import hart_miss_sched_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] rr_i,
    output logic       valid_o,
    output logic [1:0] hid_o
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        valid_o = |req_i;
        hid_o   = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < HART_STATE_W; k++) begin
            // 2-bit addition wraps naturally around the hart ring
            idx = rr_i + 2'(k);
            if (!found && req_i[idx]) begin
                hid_o = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hart_miss_sched.sv
// -----------------------------------------------------------------------------
// hart_miss_sched
// Records I/D cache misses per hart, suspends missing harts, and arbitrates the
// single shared refill port round-robin. Refill completion reactivates a hart.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   hart_en                  : harts enabled by the hart state table
//   i_miss/i_miss_hid        : I-cache miss pulse and its hart
//   d_miss/d_miss_hid        : D-cache miss pulse and its hart
//   mem_req/mem_hid/mem_is_d : refill request to the shared port
//   mem_ack, mem_fin         : port accepted / refill data delivered
//   i_cache_fin, d_cache_fin, fin_hid : completion pulse and hart id
//   susp_hstate, acti_hstate : suspended / active hart masks
//   all_susp                 : every enabled hart suspended
//   dbg_state                : refill-port FSM state (observability)
// Handshake: mem_req is held with stable mem_hid/mem_is_d until mem_ack is
// sampled high in REQ; mem_fin is honoured only in BUSY, mem_ack only in REQ.
// -----------------------------------------------------------------------------
module hart_miss_sched
    import hart_miss_sched_pkg::MS_IDLE;
    import hart_miss_sched_pkg::MS_REQ;
    import hart_miss_sched_pkg::MS_BUSY;
    import hart_miss_sched_pkg::hid_onehot;
#(
    parameter int HART_NUM  = 4,
    parameter int HART_ID_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HART_NUM-1:0]  hart_en,
    input  logic                 i_miss,
    input  logic [HART_ID_W-1:0] i_miss_hid,
    input  logic                 d_miss,
    input  logic [HART_ID_W-1:0] d_miss_hid,
    output logic                 mem_req,
    output logic [HART_ID_W-1:0] mem_hid,
    output logic                 mem_is_d,
    input  logic                 mem_ack,
    input  logic                 mem_fin,
    output logic                 i_cache_fin,
    output logic                 d_cache_fin,
    output logic [HART_ID_W-1:0] fin_hid,
    output logic [HART_NUM-1:0]  susp_hstate,
    output logic [HART_NUM-1:0]  acti_hstate,
    output logic                 all_susp,
    output logic [1:0]           dbg_state
);

    logic [1:0]           state_q,    state_d;
    logic [HART_ID_W-1:0] rr_q,       rr_d;
    logic [HART_NUM-1:0]  i_pend_q,   i_pend_d;
    logic [HART_NUM-1:0]  d_pend_q,   d_pend_d;
    logic [HART_ID_W-1:0] mem_hid_q,  mem_hid_d;
    logic                 mem_is_d_q, mem_is_d_d;
    logic                 i_fin_q,    i_fin_d;
    logic                 d_fin_q,    d_fin_d;
    logic [HART_ID_W-1:0] fin_hid_q,  fin_hid_d;

    logic                 pick_valid;
    logic [HART_ID_W-1:0] pick_hid;
    logic [HART_NUM-1:0]  keep_i, keep_d;

    rr_hart_picker u_picker (
        .req_i   (i_pend_q | d_pend_q),
        .rr_i    (rr_q),
        .valid_o (pick_valid),
        .hid_o   (pick_hid)
    );

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        mem_hid_d  = mem_hid_q;
        mem_is_d_d = mem_is_d_q;
        fin_hid_d  = fin_hid_q;
        i_fin_d    = 1'b0;
        d_fin_d    = 1'b0;
        i_pend_d   = i_pend_q;
        d_pend_d   = d_pend_q;
        keep_i     = '0;
        keep_d     = '0;

        // Miss capture: only enabled harts, and an already-set bit stays as is
        if (i_miss && hart_en[i_miss_hid] && !i_pend_q[i_miss_hid])
            i_pend_d = i_pend_d | hid_onehot(i_miss_hid);
        if (d_miss && hart_en[d_miss_hid] && !d_pend_q[d_miss_hid])
            d_pend_d = d_pend_d | hid_onehot(d_miss_hid);

        case (state_q)
            MS_IDLE: begin
                if (pick_valid) begin
                    mem_hid_d  = pick_hid;
                    mem_is_d_d = d_pend_q[pick_hid];   // D before I within a hart
                    rr_d       = pick_hid + 1'b1;
                    state_d    = MS_REQ;
                end
            end
            MS_REQ: begin
                if (mem_ack) state_d = MS_BUSY;
            end
            MS_BUSY: begin
                if (mem_fin) begin
                    // The cleared bit was set, so a same-cycle miss on it was
                    // already ignored above; the other bit's capture survives.
                    if (mem_is_d_q) begin
                        d_pend_d[mem_hid_q] = 1'b0;
                        d_fin_d = 1'b1;
                    end else begin
                        i_pend_d[mem_hid_q] = 1'b0;
                        i_fin_d = 1'b1;
                    end
                    fin_hid_d = mem_hid_q;
                    state_d   = MS_IDLE;
                end
            end
            default: state_d = MS_IDLE;
        endcase

        // A disabled hart drops its pending misses, except the one owning the
        // port after this edge: that refill must run to completion.
        if (state_d != MS_IDLE) begin
            if (mem_is_d_d) keep_d = hid_onehot(mem_hid_d);
            else            keep_i = hid_onehot(mem_hid_d);
        end
        i_pend_d = i_pend_d & (hart_en | keep_i);
        d_pend_d = d_pend_d & (hart_en | keep_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= MS_IDLE;
            rr_q       <= '0;
            i_pend_q   <= '0;
            d_pend_q   <= '0;
            mem_hid_q  <= '0;
            mem_is_d_q <= 1'b0;
            i_fin_q    <= 1'b0;
            d_fin_q    <= 1'b0;
            fin_hid_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            i_pend_q   <= i_pend_d;
            d_pend_q   <= d_pend_d;
            mem_hid_q  <= mem_hid_d;
            mem_is_d_q <= mem_is_d_d;
            i_fin_q    <= i_fin_d;
            d_fin_q    <= d_fin_d;
            fin_hid_q  <= fin_hid_d;
        end
    end

    assign mem_req     = (state_q == MS_REQ);
    assign mem_hid     = mem_hid_q;
    assign mem_is_d    = mem_is_d_q;
    assign i_cache_fin = i_fin_q;
    assign d_cache_fin = d_fin_q;
    assign fin_hid     = fin_hid_q;
    assign susp_hstate = i_pend_q | d_pend_q;
    assign acti_hstate = hart_en & ~susp_hstate;
    assign all_susp    = (acti_hstate == '0) && (hart_en != '0);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_hart_miss_sched.sv
// -----------------------------------------------------------------------------
// tb_hart_miss_sched
// Directed scenarios followed by randomized traffic; every cycle the DUT
// outputs are compared against a behavioural model of the miss scheduler.
// -----------------------------------------------------------------------------
module tb_hart_miss_sched;

    localparam logic [3:0] F = 4'b1111;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0] hart_en;
    logic       i_miss, d_miss, mem_ack, mem_fin;
    logic [1:0] i_miss_hid, d_miss_hid;
    logic       mem_req, mem_is_d, i_cache_fin, d_cache_fin, all_susp;
    logic [1:0] mem_hid, fin_hid, dbg_state;
    logic [3:0] susp_hstate, acti_hstate;

    hart_miss_sched #(.HART_NUM(4), .HART_ID_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .hart_en     (hart_en),
        .i_miss      (i_miss),
        .i_miss_hid  (i_miss_hid),
        .d_miss      (d_miss),
        .d_miss_hid  (d_miss_hid),
        .mem_req     (mem_req),
        .mem_hid     (mem_hid),
        .mem_is_d    (mem_is_d),
        .mem_ack     (mem_ack),
        .mem_fin     (mem_fin),
        .i_cache_fin (i_cache_fin),
        .d_cache_fin (d_cache_fin),
        .fin_hid     (fin_hid),
        .susp_hstate (susp_hstate),
        .acti_hstate (acti_hstate),
        .all_susp    (all_susp),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending misses per hart, plus the one refill that owns the port.
    logic [3:0] m_i, m_d;
    int         m_ph;          // 0 idle, 1 requesting, 2 waiting for data
    logic [1:0] m_h;
    logic       m_isd;
    int         m_rr;
    logic       m_fi, m_fd;
    logic [1:0] m_fh;

    function automatic void model_reset();
        m_i = '0; m_d = '0; m_ph = 0; m_h = '0; m_isd = 1'b0;
        m_rr = 0; m_fi = 1'b0; m_fd = 1'b0; m_fh = '0;
    endfunction

    function automatic void model_edge();
        logic [3:0] ni, nd;
        ni = m_i; nd = m_d;
        m_fi = 1'b0; m_fd = 1'b0;
        if (i_miss && hart_en[i_miss_hid] && !m_i[i_miss_hid]) ni[i_miss_hid] = 1'b1;
        if (d_miss && hart_en[d_miss_hid] && !m_d[d_miss_hid]) nd[d_miss_hid] = 1'b1;
        if (m_ph == 0) begin
            for (int k = 0; k < 4; k++) begin
                int h;
                h = (m_rr + k) % 4;
                if (m_i[h] || m_d[h]) begin
                    m_h   = 2'(h);
                    m_isd = m_d[h];
                    m_rr  = (h + 1) % 4;
                    m_ph  = 1;
                    break;
                end
            end
        end else if (m_ph == 1) begin
            if (mem_ack) m_ph = 2;
        end else if (mem_fin) begin
            if (m_isd) begin nd[m_h] = 1'b0; m_fd = 1'b1; end
            else       begin ni[m_h] = 1'b0; m_fi = 1'b1; end
            m_fh = m_h;
            m_ph = 0;
        end
        for (int h = 0; h < 4; h++) begin
            if (!hart_en[h]) begin
                if (!(m_ph != 0 && !m_isd && m_h == 2'(h))) ni[h] = 1'b0;
                if (!(m_ph != 0 &&  m_isd && m_h == 2'(h))) nd[h] = 1'b0;
            end
        end
        m_i = ni; m_d = nd;
    endfunction

    task automatic compare_model();
        logic [3:0] es, ea;
        es = m_i | m_d;
        ea = hart_en & ~es;
        check("state", dbg_state, 8'(m_ph));
        check("mem_req", mem_req, 8'(m_ph == 1));
        if (m_ph == 1) begin
            check("mem_hid", mem_hid, m_h);
            check("mem_is_d", mem_is_d, m_isd);
        end
        check("i_cache_fin", i_cache_fin, m_fi);
        check("d_cache_fin", d_cache_fin, m_fd);
        if (m_fi || m_fd) check("fin_hid", fin_hid, m_fh);
        check("susp_hstate", susp_hstate, es);
        check("acti_hstate", acti_hstate, ea);
        check("all_susp", all_susp, 8'((hart_en != 0) && (ea == 0)));
    endtask

    // ---------------- driver ----------------
    // One cycle: drive at negedge, compare, then advance the model at posedge.
    task automatic step(input logic [3:0] en, input logic im, input logic [1:0] ih,
                        input logic dm, input logic [1:0] dh, input logic ack, input logic fin);
        @(negedge clk);
        hart_en = en; i_miss = im; i_miss_hid = ih; d_miss = dm; d_miss_hid = dh;
        mem_ack = ack; mem_fin = fin;
        #1 compare_model();
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input logic [3:0] en);
        step(en, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    // Full refill from IDLE with a known winner; optional miss during the ack cycle.
    task automatic refill(input logic [1:0] eh, input logic ed,
                          input logic im, input logic [1:0] ih);
        idle(F);
        #2;
        check("rf_req", mem_req, 8'd1);
        check("rf_hid", mem_hid, eh);
        check("rf_is_d", mem_is_d, ed);
        step(F, im, ih, 1'b0, 2'd0, 1'b1, 1'b0);
        step(F, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        #2;
        check("rf_fin", ed ? d_cache_fin : i_cache_fin, 8'd1);
        check("rf_fin_hid", fin_hid, eh);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        hart_en = 4'b1010; i_miss = 0; i_miss_hid = 0; d_miss = 0; d_miss_hid = 0;
        mem_ack = 0; mem_fin = 0;
        model_reset();
        #12;
        check("rst_req", mem_req, 8'd0);
        check("rst_susp", susp_hstate, 8'd0);
        check("rst_acti", acti_hstate, 8'b1010);
        check("rst_all_susp", all_susp, 8'd0);
        check("rst_fin", {i_cache_fin, d_cache_fin}, 8'd0);
        @(negedge clk) rst = 1'b0;

        // Single D-miss on hart 2
        step(F, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
        #2 check("sd_acti", acti_hstate, 8'b1011);
        check("sd_noreq", mem_req, 8'd0);
        idle(F);
        #2 check("sd_req", mem_req, 8'd1);
        check("sd_hid", mem_hid, 8'd2);
        check("sd_is_d", mem_is_d, 8'd1);
        idle(F);
        #2 check("sd_req_hold", mem_req, 8'd1);
        step(F, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        #2 check("sd_req_drop", mem_req, 8'd0);
        idle(F);
        idle(F);
        step(F, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        #2 check("sd_dfin", d_cache_fin, 8'd1);
        check("sd_fin_hid", fin_hid, 8'd2);
        check("sd_acti_back", acti_hstate, 8'b1111);
        idle(F);
        #2 check("sd_fin_pulse", d_cache_fin, 8'd0);

        // Round-robin: hart 3 refill leaves rr at 0, then 0,1,3 pend together
        step(F, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
        idle(F);
        step(F, 1'b1, 2'd0, 1'b1, 2'd1, 1'b1, 1'b0);
        step(F, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b1);
        refill(2'd0, 1'b0, 1'b0, 2'd0);
        refill(2'd1, 1'b1, 1'b1, 2'd0);   // new hart 0 miss during hart 1's refill
        refill(2'd3, 1'b0, 1'b0, 2'd0);
        refill(2'd0, 1'b0, 1'b0, 2'd0);

        // Same-hart dual miss: D first, hart stays suspended until second fin
        step(F, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 1'b0);
        refill(2'd1, 1'b1, 1'b0, 2'd0);
        check("dual_still_susp", susp_hstate, 8'b0010);
        refill(2'd1, 1'b0, 1'b0, 2'd0);
        check("dual_released", susp_hstate, 8'd0);

        // Duplicate miss and disabled-hart miss
        step(F, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        step(F, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        step(F, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        step(F, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        idle(F);
        #2 check("dup_no_req", mem_req, 8'd0);
        step(4'b1110, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        #2 check("dis_no_susp", susp_hstate, 8'd0);

        // Disable hart 2 while its D refill is busy; its I-pend is dropped
        step(F, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
        step(F, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0);
        step(F, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        step(4'b1011, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        #2 check("dis_keep_d", susp_hstate, 8'b0100);
        check("dis_acti", acti_hstate, 8'b1011);
        step(4'b1011, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        #2 check("dis_fin", d_cache_fin, 8'd1);
        check("dis_fin_hid", fin_hid, 8'd2);
        check("dis_acti2", acti_hstate[2], 8'd0);
        check("dis_i_cleared", susp_hstate, 8'd0);
        idle(F);
        #2 check("dis_no_i_req", mem_req, 8'd0);

        // Asynchronous reset while requesting
        step(F, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
        idle(F);
        #2 check("ar_pre_req", mem_req, 8'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_req_low", mem_req, 8'd0);
        check("ar_susp", susp_hstate, 8'd0);
        check("ar_all_susp", all_susp, 8'd0);
        model_reset();
        @(negedge clk) rst = 1'b0;
        step(F, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
        idle(F);
        #2 check("ar_after_req", mem_req, 8'd1);
        check("ar_after_hid", mem_hid, 8'd1);

        // Randomized traffic
        begin
            logic [3:0] en;
            en = F;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 24) == 0) en = 4'($urandom_range(0, 15));
                step(en,
                     1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
